row_copy_sched: RTL and testbench
=================================

Name: row_copy_sched

Overview:
- Sequencer and arbiter for the 2-D array row-copy datapath.
- Owns the registered result array XOUT.
- Accepts row-copy commands from two requesters, grants one at a time (round-robin), and copies the selected source row of input array A or B into a destination row of XOUT, one element per cycle.
- Sits between command producers and the array datapath; the only writer of XOUT.

Parameters:
NROWS, 2, number of rows in A, B, XOUT
NCOLS, 2, number of elements per row
NBITS, 16, element width
IW, max(1, clog2(NROWS)), row index width (derived, not overridable)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ0_VALID  in  1  requester 0 command valid
REQ0_READY  out  1  requester 0 command accepted this cycle
REQ0_SRC  in  IW  source row index
REQ0_DST  in  IW  destination row index in XOUT
REQ0_SEL  in  1  source array: 0=A, 1=B
REQ1_VALID, REQ1_READY, REQ1_SRC, REQ1_DST, REQ1_SEL  same widths/meaning, requester 1
A  in  NBITS x [NROWS][NCOLS]  unsigned source array
B  in  NBITS x [NROWS][NCOLS]  signed source array
XOUT  out  NBITS x [NROWS][NCOLS]  signed result array, registered
DONE  out  1  one-cycle pulse, command complete
DONE_ID  out  1  requester index of completed command
ERR  out  1  valid with DONE; 1 = index out of range, no write performed

Behaviour:
- Reset (RST_N low, asynchronous, any state including mid-copy):
  - All XOUT elements 0; DONE, DONE_ID, ERR 0; FSM to IDLE; column counter 0.
  - Last-grant register reset to 1, so requester 0 wins the first tie.
- FSM states: IDLE, COPY, FIN.
- IDLE:
  - Combinational arbitration among VALIDs: single valid wins; both valid -> the requester not granted last wins.
  - READY high only for the winner, only in IDLE. Handshake = VALID & READY.
  - On handshake: latch SRC, DST, SEL, ID; update last-grant; counter=0.
  - On handshake, if SRC>=NROWS or DST>=NROWS: go to FIN with error flag set. Otherwise go to COPY.
- COPY:
  - In cycle with counter j, XOUT[DST][j] <= (SEL ? B : A)[SRC][j], sampled live that cycle.
  - A elements are bit-copied; no sign or width change.
  - Counter increments; after j=NCOLS-1 go to FIN.
  - Other XOUT elements hold.
- FIN:
  - DONE=1 for exactly one cycle; DONE_ID = latched ID; ERR = error flag. Next state IDLE.
  - DONE, ERR, DONE_ID are 0 in all other states.
- Latency:
  - Handshake in cycle T. Element j written at the end of cycle T+1+j. DONE in cycle T+NCOLS+1.
  - Earliest next handshake is in cycle T+NCOLS+2.
  - Throughput: one command per NCOLS+2 cycles.
- READY is 0 in COPY and FIN. Requesters must hold VALID and fields stable until READY.
- SRC==DST with SEL irrelevant is legal (A/B are inputs, no hazard).
- Back-to-back commands to the same DST: the later one overwrites.
- Input changes during COPY affect only elements not yet written.

Test Plan:
- Reset mid-copy: REQ0 copy A[0]->XOUT[1]. Assert RST_N=0 in the first COPY cycle -> XOUT all 0, DONE never pulses, REQ0_READY=1 one cycle after release if REQ0_VALID held.
- Single copy: A[0]={16'h1234,16'hFFFF}, REQ0 SRC=0 DST=1 SEL=0, handshake at T -> XOUT[1][0]=16'h1234 after T+1, XOUT[1][1]=16'hFFFF after T+2, DONE=1 DONE_ID=0 ERR=0 at T+3, XOUT[0] unchanged 0.
- Signed source: B[1]={-5,32767}, REQ1 SRC=1 DST=0 SEL=1 -> XOUT[0]={16'hFFFB,16'h7FFF}, DONE_ID=1.
- Contention: both VALID continuously after reset -> grants alternate 0,1,0,1. Each READY is high only in IDLE, and the two READYs are never high together.
- Out-of-range: NROWS=3 build, REQ0 DST=3 -> DONE with ERR=1 at T+1, XOUT unchanged.
- Busy hold: REQ1_VALID asserted at T+1 while REQ0 is copying -> REQ1_READY=0 through FIN, handshake at T+NCOLS+2 with original fields.

Source files
------------

// File: rtl/row_copy_sched.sv
// Round-robin arbiter and sequencer for 2-D row copies into the registered XOUT array.
// One command at a time; the chosen source row is copied one element per cycle.
module row_copy_sched #(
    parameter int NROWS = 2,
    parameter int NCOLS = 2,
    parameter int NBITS = 16,
    localparam int IW = (NROWS > 1) ? $clog2(NROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [IW-1:0]           req0_src,
    input  logic [IW-1:0]           req0_dst,
    input  logic                    req0_sel,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [IW-1:0]           req1_src,
    input  logic [IW-1:0]           req1_dst,
    input  logic                    req1_sel,
    input  logic        [NBITS-1:0] a    [NROWS][NCOLS],
    input  logic signed [NBITS-1:0] b    [NROWS][NCOLS],
    output logic signed [NBITS-1:0] xout [NROWS][NCOLS],
    output logic                    done,
    output logic                    done_id,
    output logic                    err
);
    localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COPY = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [CW-1:0]    col_reg;
    logic [IW-1:0]    src_reg, dst_reg;
    logic             sel_reg, id_reg, err_reg, last_grant_reg;

    logic             idle, grant0, grant1, hs, hs_id, hs_sel, hs_bad, last_col;
    logic [IW-1:0]    hs_src, hs_dst;
    logic [NBITS-1:0] copy_data;

    // Tie goes to whichever requester was not granted last.
    assign idle       = (state_reg == S_IDLE);
    assign grant0     = req0_valid && (!req1_valid || last_grant_reg);
    assign grant1     = req1_valid && (!req0_valid || !last_grant_reg);
    assign req0_ready = idle && grant0;
    assign req1_ready = idle && grant1;
    assign hs         = req0_ready || req1_ready;
    assign hs_id      = req1_ready;
    assign hs_src     = hs_id ? req1_src : req0_src;
    assign hs_dst     = hs_id ? req1_dst : req0_dst;
    assign hs_sel     = hs_id ? req1_sel : req0_sel;
    assign hs_bad     = (int'(hs_src) >= NROWS) || (int'(hs_dst) >= NROWS);
    assign last_col   = (col_reg == CW'(NCOLS - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (hs) state_next = hs_bad ? S_FIN : S_COPY;
            S_COPY:  if (last_col) state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            col_reg        <= '0;
            src_reg        <= '0;
            dst_reg        <= '0;
            sel_reg        <= 1'b0;
            id_reg         <= 1'b0;
            err_reg        <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (hs) begin
                src_reg        <= hs_src;
                dst_reg        <= hs_dst;
                sel_reg        <= hs_sel;
                id_reg         <= hs_id;
                err_reg        <= hs_bad;
                last_grant_reg <= hs_id;
                col_reg        <= '0;
            end else if (state_reg == S_COPY) begin
                col_reg <= last_col ? '0 : col_reg + CW'(1);
            end
        end
    end

    // Source element is sampled live in the cycle it is written.
    assign copy_data = sel_reg ? b[src_reg][col_reg] : a[src_reg][col_reg];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NROWS; gi++) begin : g_row
            for (gj = 0; gj < NCOLS; gj++) begin : g_col
                logic [NBITS-1:0] elem_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        elem_reg <= '0;
                    end else if (state_reg == S_COPY && dst_reg == IW'(gi) && col_reg == CW'(gj)) begin
                        elem_reg <= copy_data;
                    end
                end
                assign xout[gi][gj] = elem_reg;
            end
        end
    endgenerate

    assign done    = (state_reg == S_FIN);
    assign done_id = done && id_reg;
    assign err     = done && err_reg;

endmodule

// File: tb/tb_row_copy_sched.sv
// Randomized bench for row_copy_sched (3-row build so out-of-range indices are reachable),
// compared every cycle against a transaction-level timing model.
module tb_row_copy_sched;
    localparam int NR = 3;
    localparam int NC = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic               req0_ready, req1_ready, done, done_id, err;
    logic        [15:0] a    [NR][NC];
    logic signed [15:0] b    [NR][NC];
    logic signed [15:0] xout [NR][NC];

    // pending command per requester, held until accepted
    logic       pv [2];
    logic [1:0] ps [2];
    logic [1:0] pd [2];
    logic       pl [2];

    // reference model
    logic [15:0] xm [NR][NC];
    logic        m_last, m_id, m_sel, m_err;
    logic [1:0]  m_src, m_dst;
    int          m_k;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    row_copy_sched #(.NROWS(NR), .NCOLS(NC), .NBITS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(pv[0]), .req0_ready(req0_ready), .req0_src(ps[0]), .req0_dst(pd[0]), .req0_sel(pl[0]),
        .req1_valid(pv[1]), .req1_ready(req1_ready), .req1_src(ps[1]), .req1_dst(pd[1]), .req1_sel(pl[1]),
        .a(a), .b(b), .xout(xout),
        .done(done), .done_id(done_id), .err(err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic m_reset();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) xm[r][c] = '0;
        m_last = 1'b1;
        m_k = 0;
        m_err = 1'b0;
        m_id = 1'b0;
    endtask

    // one cycle: check outputs at negedge, advance model at posedge, return #1 after edge
    task automatic tick();
        logic idle, g0, g1, fin;
        int hs_id;
        hs_id = -1;
        @(negedge clk);
        idle = (m_k == 0);
        g0 = pv[0] && (!pv[1] || m_last);
        g1 = pv[1] && (!pv[0] || !m_last);
        fin = !idle && (m_err ? (m_k == 1) : (m_k == NC + 1));
        check_eq("ready0", req0_ready, idle && g0);
        check_eq("ready1", req1_ready, idle && g1);
        check_eq("done", done, fin);
        check_eq("done_id", done_id, fin && m_id);
        check_eq("err", err, fin && m_err);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                check_eq($sformatf("xout[%0d][%0d]", r, c), {48'h0, xout[r][c]}, {48'h0, xm[r][c]});
        @(posedge clk);
        if (rst_n) begin
            if (idle) begin
                if (g0 || g1) begin
                    hs_id = g1 ? 1 : 0;
                    m_id = g1;
                    m_src = ps[hs_id];
                    m_dst = pd[hs_id];
                    m_sel = pl[hs_id];
                    m_last = g1;
                    m_err = (int'(m_src) >= NR) || (int'(m_dst) >= NR);
                    m_k = 1;
                end
            end else if (fin) begin
                m_k = 0;
            end else begin
                if (!m_err) xm[m_dst][m_k-1] = m_sel ? b[m_src][m_k-1] : a[m_src][m_k-1];
                m_k++;
            end
        end
        #1;
        if (hs_id >= 0) pv[hs_id] = 1'b0;
    endtask

    function automatic logic [1:0] rnd_idx();
        return ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    endfunction

    initial begin
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                a[r][c] = '0;
                b[r][c] = '0;
            end
        for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0; ps[i] = '0; pd[i] = '0; pl[i] = 1'b0;
        end
        rst_n = 1'b0;
        m_reset();
        tick();
        tick();
        rst_n = 1'b1;

        // single unsigned copy A[0] -> XOUT[1]
        a[0][0] = 16'h1234;
        a[0][1] = 16'hFFFF;
        pv[0] = 1'b1; ps[0] = 2'd0; pd[0] = 2'd1; pl[0] = 1'b0;
        tick(); tick(); tick();
        check_eq("dir_x10", {48'h0, xout[1][0]}, 64'h1234);
        check_eq("dir_x11", {48'h0, xout[1][1]}, 64'hFFFF);
        check_eq("dir_x00", {48'h0, xout[0][0]}, 64'h0);
        tick();

        // signed copy B[1] -> XOUT[0] from requester 1
        b[1][0] = -16'sd5;
        b[1][1] = 16'sd32767;
        pv[1] = 1'b1; ps[1] = 2'd1; pd[1] = 2'd0; pl[1] = 1'b1;
        tick(); tick(); tick();
        check_eq("dir_x00s", {48'h0, xout[0][0]}, 64'hFFFB);
        check_eq("dir_x01s", {48'h0, xout[0][1]}, 64'h7FFF);
        tick();

        // reset in the first copy cycle
        pv[0] = 1'b1; ps[0] = 2'd0; pd[0] = 2'd2; pl[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        m_reset();
        tick();
        check_eq("rst_x10", {48'h0, xout[1][0]}, 64'h0);
        rst_n = 1'b1;
        pv[0] = 1'b1;
        tick();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                m_reset();
            end
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 3) != 0) begin
                    pv[i] = 1'b1;
                    ps[i] = rnd_idx();
                    pd[i] = rnd_idx();
                    pl[i] = 1'($urandom_range(0, 1));
                end
            end
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++) begin
                    if ($urandom_range(0, 2) == 0) a[r][c] = 16'($urandom);
                    if ($urandom_range(0, 2) == 0) b[r][c] = 16'($urandom);
                end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
